execute_stage: RTL and testbench

- EX stage datapath plus EX/MEM pipeline register of the 5-stage RISC-V pipeline.
- Consumes the 4-bit ALUControl code produced by the ALU control decoder.
- Resolves forwarded operands, computes the ALU result and the branch Zero flag, and registers results for the MEM stage.
- Supports a stall (hold) and a flush (bubble insert) on the EX/MEM register.

---
 rtl/execute_stage.sv | 177 +++++++++++++++++
 tb/tb_execute_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// ============================================================================
// Module   : execute_stage
// Purpose  : EX stage datapath and EX/MEM pipeline register of a 5-stage
//            RISC-V pipeline. Selects forwarded operands, computes the ALU
//            result and the branch Zero flag, and registers results for MEM.
// Ports    : clk, reset            - clock (rising edge), async active-high reset
//            ValidE                - EX holds a real instruction
//            ALUControlE[3:0]      - ALU operation code
//            ALUSrcE               - 0: SrcB = forwarded RD2, 1: SrcB = ImmExtE
//            RD1E, RD2E, ImmExtE   - register operands and immediate
//            ForwardAE/BE[1:0]     - 00/11: RDxE, 01: ResultW, 10: ALUResultM
//            ResultW               - writeback result
//            RdE, RegWriteE, MemWriteE, ResultSrcE - carried-through fields
//            StallM, FlushM        - EX/MEM hold / bubble insert
//            ZeroE                 - combinational ALU-result-is-zero flag
//            *M outputs            - registered EX/MEM contents
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidE,
    input  logic [3:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            StallM,
    input  logic            FlushM,
    output logic            ZeroE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic            ValidM
);

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_XOR  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_AND  = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRL  = 4'b0110;
    localparam logic [3:0] c_ALU_SRA  = 4'b0111;
    localparam logic [3:0] c_ALU_SLT  = 4'b1000;
    localparam logic [3:0] c_ALU_SLTU = 4'b1001;

    // EX/MEM register state
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic [4:0]      rd_q,         rd_d;
    logic            reg_write_q,  reg_write_d;
    logic            mem_write_q,  mem_write_d;
    logic [1:0]      result_src_q, result_src_d;
    logic            valid_q,      valid_d;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result_e;
    logic [SHAMT_W-1:0] shamt;

    // Forward muxes. Source 10 is the registered EX/MEM result, so during a
    // stall the held value is what gets forwarded.
    always_comb begin
        src_a = RD1E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_q;
            default: src_a = RD1E;
        endcase
    end

    always_comb begin
        write_data_e = RD2E;
        case (ForwardBE)
            2'b01:   write_data_e = ResultW;
            2'b10:   write_data_e = alu_result_q;
            default: write_data_e = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExtE : write_data_e;
    // Only the low log2(XLEN) bits of SrcB form the shift amount.
    assign shamt = src_b[SHAMT_W-1:0];

    always_comb begin
        alu_result_e = '0;
        case (ALUControlE)
            c_ALU_ADD:  alu_result_e = src_a + src_b;
            c_ALU_SUB:  alu_result_e = src_a - src_b;
            c_ALU_XOR:  alu_result_e = src_a ^ src_b;
            c_ALU_OR:   alu_result_e = src_a | src_b;
            c_ALU_AND:  alu_result_e = src_a & src_b;
            c_ALU_SLL:  alu_result_e = src_a << shamt;
            c_ALU_SRL:  alu_result_e = src_a >> shamt;
            c_ALU_SRA:  alu_result_e = $unsigned($signed(src_a) >>> shamt);
            c_ALU_SLT:  alu_result_e = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            c_ALU_SLTU: alu_result_e = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default:    alu_result_e = '0;
        endcase
    end

    assign ZeroE = (alu_result_e == '0);

    // Next-state for EX/MEM: flush beats stall; a flush clears only the
    // control/valid/rd fields and leaves the data fields as they were.
    always_comb begin
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        result_src_d = result_src_q;
        valid_d      = valid_q;
        if (FlushM) begin
            rd_d        = 5'd0;
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
            valid_d     = 1'b0;
        end else if (!StallM) begin
            alu_result_d = alu_result_e;
            write_data_d = write_data_e;
            rd_d         = RdE;
            reg_write_d  = RegWriteE & ValidE;
            mem_write_d  = MemWriteE & ValidE;
            result_src_d = ResultSrcE;
            valid_d      = ValidE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            valid_q      <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            valid_q      <= valid_d;
        end
    end

    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign RdM        = rd_q;
    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign ValidM     = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed self-checking bench for execute_stage (XLEN = 32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic        ValidE;
    logic [3:0]  ALUControlE;
    logic        ALUSrcE;
    logic [31:0] RD1E, RD2E, ImmExtE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic        StallM, FlushM;
    logic        ZeroE;
    logic [31:0] ALUResultM, WriteDataM;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic        ValidM;

    int n_cmp = 0;
    int n_err = 0;

    execute_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .ValidE      (ValidE),
        .ALUControlE (ALUControlE),
        .ALUSrcE     (ALUSrcE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
        .RdE         (RdE),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .StallM      (StallM),
        .FlushM      (FlushM),
        .ZeroE       (ZeroE),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .RdM         (RdM),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .ValidM      (ValidM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set up a valid register-register or register-immediate operation.
    task automatic op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                      input logic src, input logic [31:0] imm);
        ValidE      = 1'b1;
        ALUControlE = ctl;
        RD1E        = a;
        RD2E        = b;
        ALUSrcE     = src;
        ImmExtE     = imm;
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
    endtask

    initial begin
        reset = 1'b1; ValidE = 1'b0; ALUControlE = 4'h0; ALUSrcE = 1'b0;
        RD1E = '0; RD2E = '0; ImmExtE = '0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        ResultW = '0; RdE = 5'd0; RegWriteE = 1'b0; MemWriteE = 1'b0;
        ResultSrcE = 2'b00; StallM = 1'b0; FlushM = 1'b0;
        tick();
        reset = 1'b0;

        // Fill the pipe, then hit reset mid-cycle.
        op(4'b0000, 32'd1, 32'd2, 1'b0, '0);
        RdE = 5'd9; RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'b01;
        tick();
        chk("full_valid", {31'd0, ValidM}, 32'd1);
        chk("full_alu", ALUResultM, 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("rst_alu",   ALUResultM, 32'd0);
        chk("rst_wd",    WriteDataM, 32'd0);
        chk("rst_ctrl",  {25'd0, RdM, RegWriteM, MemWriteM}, 32'd0);
        chk("rst_rsrc",  {30'd0, ResultSrcM}, 32'd0);
        chk("rst_valid", {31'd0, ValidM}, 32'd0);
        #2 reset = 1'b0;
        tick();

        // ADD 5 + 7
        op(4'b0000, 32'd5, 32'd7, 1'b0, '0);
        tick();
        chk("add", ALUResultM, 32'd12);
        chk("add_valid", {31'd0, ValidM}, 32'd1);
        chk("add_ctrl", {25'd0, RdM, RegWriteM, MemWriteM}, {25'd0, 5'd9, 1'b1, 1'b1});

        // SUB 3 - 3, Zero combinational
        op(4'b0001, 32'd3, 32'd3, 1'b0, '0);
        #1;
        chk("sub_zero", {31'd0, ZeroE}, 32'd1);
        op(4'b1000, 32'hFFFF_FFFF, 32'd1, 1'b0, '0);
        #1;
        chk("slt_zero", {31'd0, ZeroE}, 32'd0);
        tick();
        chk("slt", ALUResultM, 32'd1);
        op(4'b1001, 32'hFFFF_FFFF, 32'd1, 1'b0, '0);
        tick();
        chk("sltu", ALUResultM, 32'd0);
        op(4'b1100, 32'd5, 32'd7, 1'b0, '0);
        #1;
        chk("undef_zero", {31'd0, ZeroE}, 32'd1);
        tick();
        chk("undef", ALUResultM, 32'd0);

        // Shifts via immediate; 0x24 uses only shamt bits -> 4
        op(4'b0111, 32'h8000_0000, 32'd0, 1'b1, 32'h0000_0024);
        tick();
        chk("sra", ALUResultM, 32'hF800_0000);
        op(4'b0110, 32'h8000_0000, 32'd0, 1'b1, 32'h0000_0024);
        tick();
        chk("srl", ALUResultM, 32'h0800_0000);
        op(4'b0101, 32'd1, 32'd31, 1'b0, '0);
        tick();
        chk("sll", ALUResultM, 32'h8000_0000);
        op(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, '0);
        tick();
        chk("xor", ALUResultM, 32'h0FF0_0FF0);
        op(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, '0);
        tick();
        chk("and", ALUResultM, 32'hF000_F000);
        op(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, '0);
        tick();
        chk("or", ALUResultM, 32'hFFF0_FFF0);

        // Forwarding chain
        op(4'b0000, 32'd10, 32'd20, 1'b0, '0);
        tick();
        chk("fwd_base", ALUResultM, 32'd30);
        op(4'b0000, 32'd999, 32'd1, 1'b0, '0);
        ForwardAE = 2'b10;
        tick();
        chk("fwd_a_m", ALUResultM, 32'd31);
        op(4'b0000, 32'd0, 32'h77, 1'b0, '0);
        ForwardBE = 2'b01; ResultW = 32'h55; MemWriteE = 1'b1;
        tick();
        chk("fwd_b_w", WriteDataM, 32'h55);
        chk("fwd_b_alu", ALUResultM, 32'h55);
        chk("fwd_b_mw", {31'd0, MemWriteM}, 32'd1);

        // Stall two cycles while E inputs change; held value is forwarded
        StallM = 1'b1;
        op(4'b0001, 32'd0, 32'h55, 1'b0, '0);
        ForwardAE = 2'b10; RdE = 5'd3; RegWriteE = 1'b0; MemWriteE = 1'b0;
        #1;
        chk("stall_fwd_zero", {31'd0, ZeroE}, 32'd1);
        tick();
        chk("stall1_alu", ALUResultM, 32'h55);
        RD2E = 32'h1234;
        tick();
        chk("stall2_alu", ALUResultM, 32'h55);
        chk("stall2_wd", WriteDataM, 32'h55);
        chk("stall2_ctrl", {25'd0, RdM, RegWriteM, MemWriteM}, {25'd0, 5'd9, 1'b1, 1'b1});

        // Stall with flush: flush wins, data fields unchanged
        FlushM = 1'b1;
        tick();
        chk("flush_ctrl", {25'd0, RdM, RegWriteM, MemWriteM}, 32'd0);
        chk("flush_valid", {31'd0, ValidM}, 32'd0);
        chk("flush_alu", ALUResultM, 32'h55);
        FlushM = 1'b0; StallM = 1'b0;

        // Bubble: ValidE=0 gates control bits
        op(4'b0000, 32'd1, 32'd1, 1'b0, '0);
        ValidE = 1'b0; RegWriteE = 1'b1; MemWriteE = 1'b1;
        tick();
        chk("bubble_ctrl", {30'd0, RegWriteM, MemWriteM}, 32'd0);
        chk("bubble_valid", {31'd0, ValidM}, 32'd0);

        // Reset in the middle of a stall, then release loads normally
        op(4'b0000, 32'd8, 32'd8, 1'b0, '0);
        RdE = 5'd7;
        tick();
        chk("pre_rst_alu", ALUResultM, 32'd16);
        StallM = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("stall_rst_alu", ALUResultM, 32'd0);
        chk("stall_rst_valid", {31'd0, ValidM}, 32'd0);
        tick();
        reset = 1'b0; StallM = 1'b0;
        op(4'b0000, 32'd2, 32'd2, 1'b0, '0);
        tick();
        chk("post_rst_alu", ALUResultM, 32'd4);
        chk("post_rst_ctrl", {25'd0, RdM, RegWriteM, MemWriteM, ValidM}, {24'd0, 5'd7, 1'b1, 1'b1, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
